// File: rtl/tbec_pkg.sv
// Shared types and helpers for the pipelined TBEC decoder.
// Contents: codeword struct, error-code enum, check-field bit positions,
// and tbec_checks(), which recomputes {diag, par, chk} from 16 data bits.
// Data bit naming: row A..D = 0..3, index 1..4; Li sits at d[15 - row - 4*(i-1)].
package tbec_pkg;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  diag;  // {DI1, DI4, DI2, DI3}
    logic [3:0]  par;   // {P1, P4, P2, P3}
    logic [7:0]  chk;   // {XA13, XA24, XB13, XB24, XC13, XC24, XD13, XD24}
  } tbec_cw_t;

  typedef enum logic [1:0] {
    TBEC_NONE = 2'b00,
    TBEC_R1   = 2'b01,
    TBEC_R2   = 2'b10,
    TBEC_R3   = 2'b11
  } tbec_code_e;

  localparam int DI1_BIT = 3;
  localparam int DI4_BIT = 2;
  localparam int DI2_BIT = 1;
  localparam int DI3_BIT = 0;
  localparam int P1_BIT  = 3;
  localparam int P4_BIT  = 2;
  localparam int P2_BIT  = 1;
  localparam int P3_BIT  = 0;

  function automatic logic [3:0] lpos(input int row, input int idx);
    return 4'(15 - row - 4 * (idx - 1));
  endfunction

  function automatic logic [2:0] x13pos(input int row);
    return 3'(7 - 2 * row);
  endfunction

  function automatic logic [2:0] x24pos(input int row);
    return 3'(6 - 2 * row);
  endfunction

  // Returns the expected {diag, par, chk} for data word d.
  function automatic logic [15:0] tbec_checks(input logic [15:0] d);
    logic [3:0] diag;
    logic [3:0] par;
    logic [7:0] chk;
    diag[DI1_BIT] = d[lpos(0,1)] ^ d[lpos(1,2)] ^ d[lpos(2,1)] ^ d[lpos(3,2)];
    diag[DI2_BIT] = d[lpos(0,2)] ^ d[lpos(1,1)] ^ d[lpos(2,2)] ^ d[lpos(3,1)];
    diag[DI3_BIT] = d[lpos(0,3)] ^ d[lpos(1,4)] ^ d[lpos(2,3)] ^ d[lpos(3,4)];
    diag[DI4_BIT] = d[lpos(0,4)] ^ d[lpos(1,3)] ^ d[lpos(2,4)] ^ d[lpos(3,3)];
    par[P1_BIT]   = d[lpos(0,1)] ^ d[lpos(0,2)] ^ d[lpos(1,1)] ^ d[lpos(1,2)];
    par[P2_BIT]   = d[lpos(2,1)] ^ d[lpos(2,2)] ^ d[lpos(3,1)] ^ d[lpos(3,2)];
    par[P3_BIT]   = d[lpos(0,3)] ^ d[lpos(0,4)] ^ d[lpos(1,3)] ^ d[lpos(1,4)];
    par[P4_BIT]   = d[lpos(2,3)] ^ d[lpos(2,4)] ^ d[lpos(3,3)] ^ d[lpos(3,4)];
    chk = '0;
    for (int r = 0; r < 4; r++) begin
      chk[x13pos(r)] = d[lpos(r,1)] ^ d[lpos(r,3)];
      chk[x24pos(r)] = d[lpos(r,2)] ^ d[lpos(r,4)];
    end
    return {diag, par, chk};
  endfunction

endpackage

// File: rtl/tbec_syndrome_calc.sv
// Combinational syndrome generator for one 32-bit TBEC codeword.
// Ports: cw  - received codeword {data, diag, par, chk}
//        syn - 16 syndrome bits laid out like the check field {sdiag, spar, schk}
module tbec_syndrome_calc
  import tbec_pkg::*;
(
  input  logic [31:0] cw,
  output logic [15:0] syn
);

  tbec_cw_t c;
  assign c   = cw;
  assign syn = tbec_checks(c.data) ^ {c.diag, c.par, c.chk};

endmodule

// File: rtl/tbec_decoder_pipe.sv
// Two-stage pipelined multi-lane TBEC decoder with a valid/ready stream.
// Stage 1 holds received data + syndromes, stage 2 holds the corrected result.
// Ports: clk, rst (async, active high); in_valid/in_ready/in_word (32b per lane);
//        out_valid/out_ready/out_word (16b per lane), error_code (2b per lane),
//        uncorrectable (1b per lane); cnt_clr and cnt_r1/r2/r3/unc statistics.
// Build option: define TBEC_ERR_CNT_EN to build the saturating statistics
// counters; without it the counter outputs are tied to 0 and cnt_clr is ignored.
module tbec_decoder_pipe
  import tbec_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*NUM_LANES-1:0] in_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*NUM_LANES-1:0] out_word,
  output logic [2*NUM_LANES-1:0] error_code,
  output logic [NUM_LANES-1:0]   uncorrectable,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       cnt_r1,
  output logic [CNT_W-1:0]       cnt_r2,
  output logic [CNT_W-1:0]       cnt_r3,
  output logic [CNT_W-1:0]       cnt_unc
);

  logic [NUM_LANES-1:0][15:0] syn_c;
  logic [NUM_LANES-1:0][15:0] s1_data;
  logic [NUM_LANES-1:0][15:0] s1_syn;
  logic                       s1_valid;
  logic                       s2_valid;
  logic                       s1_adv;
  logic                       s2_adv;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    tbec_syndrome_calc u_syn (
      .cw  (in_word[32*k +: 32]),
      .syn (syn_c[k])
    );
  end

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < NUM_LANES; k++) s1_data[k] <= in_word[32*k+16 +: 16];
        s1_syn <= syn_c;
      end
    end
  end

  logic [NUM_LANES-1:0][15:0] fix_data;
  logic [NUM_LANES-1:0][1:0]  fix_code;
  logic [NUM_LANES-1:0]       fix_unc;
  logic [3:0]                 sdiag;
  logic [3:0]                 spar;
  logic [7:0]                 schk;
  logic [2:0]                 s12;
  logic [2:0]                 s34;
  logic                       cond;
  tbec_code_e                 code;
  logic [15:0]                wd;

  always_comb begin
    fix_data = s1_data;
    fix_code = '0;
    fix_unc  = '0;
    sdiag    = '0;
    spar     = '0;
    schk     = '0;
    s12      = '0;
    s34      = '0;
    cond     = 1'b0;
    code     = TBEC_NONE;
    wd       = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      sdiag = s1_syn[k][15:12];
      spar  = s1_syn[k][11:8];
      schk  = s1_syn[k][7:0];
      s12   = 3'(sdiag[DI1_BIT]) + 3'(sdiag[DI2_BIT]) + 3'(spar[P1_BIT]) + 3'(spar[P2_BIT]);
      s34   = 3'(sdiag[DI3_BIT]) + 3'(sdiag[DI4_BIT]) + 3'(spar[P3_BIT]) + 3'(spar[P4_BIT]);
      cond  = ((|sdiag) && (|spar)) || ($countones(schk) > 1);
      if (!cond)          code = TBEC_NONE;
      else if (s12 > s34) code = TBEC_R1;
      else if (s12 < s34) code = TBEC_R2;
      else                code = TBEC_R3;
      wd = s1_data[k];
      // Each row's X13/X24 syndrome is steered onto the bit pair the region implicates.
      for (int r = 0; r < 4; r++) begin
        case (code)
          TBEC_R1: begin
            wd[lpos(r,1)] = wd[lpos(r,1)] ^ schk[x13pos(r)];
            wd[lpos(r,2)] = wd[lpos(r,2)] ^ schk[x24pos(r)];
          end
          TBEC_R2: begin
            wd[lpos(r,3)] = wd[lpos(r,3)] ^ schk[x13pos(r)];
            wd[lpos(r,4)] = wd[lpos(r,4)] ^ schk[x24pos(r)];
          end
          TBEC_R3: begin
            wd[lpos(r,2)] = wd[lpos(r,2)] ^ schk[x24pos(r)];
            wd[lpos(r,3)] = wd[lpos(r,3)] ^ schk[x13pos(r)];
          end
          default: ;
        endcase
      end
      fix_data[k] = wd;
      fix_code[k] = code;
      fix_unc[k]  = !cond && (|s1_syn[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid      <= 1'b0;
      out_word      <= '0;
      error_code    <= '0;
      uncorrectable <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_word      <= fix_data;
        error_code    <= fix_code;
        uncorrectable <= fix_unc;
      end
    end
  end

`ifdef TBEC_ERR_CNT_EN
  logic [3:0]       n_r1;
  logic [3:0]       n_r2;
  logic [3:0]       n_r3;
  logic [3:0]       n_unc;
  logic [CNT_W-1:0] r1_q;
  logic [CNT_W-1:0] r2_q;
  logic [CNT_W-1:0] r3_q;
  logic [CNT_W-1:0] unc_q;

  always_comb begin
    n_r1  = '0;
    n_r2  = '0;
    n_r3  = '0;
    n_unc = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      n_r1  = n_r1  + {3'b0, error_code[2*k +: 2] == TBEC_R1};
      n_r2  = n_r2  + {3'b0, error_code[2*k +: 2] == TBEC_R2};
      n_r3  = n_r3  + {3'b0, error_code[2*k +: 2] == TBEC_R3};
      n_unc = n_unc + {3'b0, uncorrectable[k]};
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [3:0] n);
    logic [CNT_W+3:0] s;
    s = {4'b0, c} + {{CNT_W{1'b0}}, n};
    return (s > {4'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      unc_q <= '0;
    end else if (cnt_clr) begin
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      unc_q <= '0;
    end else if (s2_valid && out_ready) begin
      r1_q  <= sat_add(r1_q, n_r1);
      r2_q  <= sat_add(r2_q, n_r2);
      r3_q  <= sat_add(r3_q, n_r3);
      unc_q <= sat_add(unc_q, n_unc);
    end
  end

  assign cnt_r1  = r1_q;
  assign cnt_r2  = r2_q;
  assign cnt_r3  = r3_q;
  assign cnt_unc = unc_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_r1  = '0;
  assign cnt_r2  = '0;
  assign cnt_r3  = '0;
  assign cnt_unc = '0;
`endif

endmodule
